// File: rtl/safe_pkg.sv
// Shared state encoding and field widths for the safe lockout controller.
package safe_pkg;

  localparam int STATE_W = 3;
  localparam int FAILS_W = 4;

  localparam logic [STATE_W-1:0] CODE_SETUP   = 3'd0;
  localparam logic [STATE_W-1:0] CODE_ARMED   = 3'd1;
  localparam logic [STATE_W-1:0] CODE_CHECK   = 3'd2;
  localparam logic [STATE_W-1:0] CODE_OPEN    = 3'd3;
  localparam logic [STATE_W-1:0] CODE_LOCKOUT = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    ST_SETUP   = CODE_SETUP,
    ST_ARMED   = CODE_ARMED,
    ST_CHECK   = CODE_CHECK,
    ST_OPEN    = CODE_OPEN,
    ST_LOCKOUT = CODE_LOCKOUT
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus registered rising-edge detector for the enter button.
// A pulse is only produced once the input has been seen low after reset.
module sync_edge (
  input  logic CLK50,
  input  logic reset,
  input  logic in,
  output logic pulse
);

  logic       r_s1;
  logic       r_s2;
  logic       r_s3;
  logic [1:0] r_fill;
  logic       r_seen_low;
  logic       r_pulse;

  // r_fill marks when r_s2 holds a genuine sample rather than its reset value,
  // so a button already held through reset cannot fake a rising edge.
  always_ff @(posedge CLK50 or negedge reset) begin
    if (!reset) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_s3       <= 1'b0;
      r_fill     <= 2'b00;
      r_seen_low <= 1'b0;
      r_pulse    <= 1'b0;
    end else begin
      r_s1       <= in;
      r_s2       <= r_s1;
      r_s3       <= r_s2;
      r_fill     <= {r_fill[0], 1'b1};
      r_seen_low <= r_seen_low | (r_fill[1] & ~r_s2);
      r_pulse    <= r_s2 & ~r_s3 & r_seen_low;
    end
  end

  assign pulse = r_pulse;

endmodule

// File: rtl/safe_lockout_ctrl.sv
// Control FSM for a password safe: setup, arming, one-cycle match check,
// open state and a timed lockout after too many consecutive wrong attempts.
module safe_lockout_ctrl
  import safe_pkg::*;
#(
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 250_000_000
) (
  input  logic               CLK50,
  input  logic               reset,
  input  logic               E,
  input  logic               M,
  output logic               savePW,
  output logic               saveAT,
  output logic               LOCKED,
  output logic [STATE_W-1:0] PRESENT_STATE,
  output logic [FAILS_W-1:0] FAILS,
  output logic               LOCKOUT
);

  localparam int                 TIMER_W    = $clog2(LOCKOUT_CYCLES) + 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [FAILS_W-1:0] FAILS_MAX  = FAILS_W'(MAX_FAILS);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [FAILS_W-1:0] r_fails;
  logic [FAILS_W-1:0] w_fails_nxt;
  logic [FAILS_W-1:0] w_fails_inc;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] w_timer_nxt;
  logic               w_enter;
  logic               w_save_pw;
  logic               w_save_at;

  function automatic logic [FAILS_W-1:0] sat_inc(input logic [FAILS_W-1:0] v);
    return (v >= FAILS_MAX) ? FAILS_MAX : v + 4'd1;
  endfunction

  sync_edge u_sync_edge (
    .CLK50 (CLK50),
    .reset (reset),
    .in    (E),
    .pulse (w_enter)
  );

  assign w_fails_inc = sat_inc(r_fails);

  always_ff @(posedge CLK50 or negedge reset) begin
    if (!reset) begin
      r_state <= ST_SETUP;
      r_fails <= '0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fails <= w_fails_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  // Strobes are decoded from the state register and the registered enter pulse,
  // so the datapath latches switches on the same edge the state advances.
  always_comb begin
    w_state_nxt = r_state;
    w_fails_nxt = r_fails;
    w_timer_nxt = r_timer;
    w_save_pw   = 1'b0;
    w_save_at   = 1'b0;
    case (r_state)
      ST_SETUP: begin
        if (w_enter) begin
          w_state_nxt = ST_ARMED;
          w_save_pw   = 1'b1;
        end
      end
      ST_ARMED: begin
        if (w_enter) begin
          w_state_nxt = ST_CHECK;
          w_save_at   = 1'b1;
        end
      end
      ST_CHECK: begin
        if (M) begin
          w_state_nxt = ST_OPEN;
          w_fails_nxt = '0;
        end else if (w_fails_inc >= FAILS_MAX) begin
          w_state_nxt = ST_LOCKOUT;
          w_fails_nxt = FAILS_MAX;
          w_timer_nxt = TIMER_LOAD;
        end else begin
          w_state_nxt = ST_ARMED;
          w_fails_nxt = w_fails_inc;
        end
      end
      ST_OPEN: begin
        if (w_enter) begin
          w_state_nxt = ST_ARMED;
          w_save_pw   = 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (r_timer == '0) begin
          w_state_nxt = ST_ARMED;
          w_fails_nxt = '0;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_SETUP;
      end
    endcase
  end

  assign savePW        = w_save_pw;
  assign saveAT        = w_save_at;
  assign LOCKED        = (r_state != ST_SETUP) && (r_state != ST_OPEN);
  assign LOCKOUT       = (r_state == ST_LOCKOUT);
  assign PRESENT_STATE = r_state;
  assign FAILS         = r_fails;

endmodule

// File: doc/safe_lockout_ctrl.md
SAFE_LOCKOUT_CTRL -- requirements
Module: safe_lockout_ctrl

Interface
REQ-001 SHALL provide parameter MAX_FAILS, default 3, consecutive wrong attempts that trigger lockout (1..15).
REQ-002 SHALL provide parameter LOCKOUT_CYCLES, default 250_000_000, lockout duration in CLK50 cycles (>=1).
REQ-003 CLK50  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 E  input  1  enter request, active-high level (already-inverted button), asynchronous to CLK50.
REQ-006 M  input  1  datapath match flag (ATTEMPT == PASSWORD).
REQ-007 savePW  output  1  one-cycle strobe: datapath loads PASSWORD from switches.
REQ-008 saveAT  output  1  one-cycle strobe: datapath loads ATTEMPT from switches.
REQ-009 LOCKED  output  1  high in every state except SETUP and OPEN.
REQ-010 PRESENT_STATE  output  3  current state encoding.
REQ-011 FAILS  output  4  consecutive failed-attempt count.
REQ-012 LOCKOUT  output  1  high while in LOCKOUT state.

Function
REQ-013 States SHALL be SETUP=0, ARMED=1, CHECK=2, OPEN=3, LOCKOUT=4; codes 5-7 SHALL return to SETUP next cycle.
REQ-014 E SHALL pass a two-flop synchronizer then rising-edge detect; resulting one-cycle "enter" occurs 3 cycles after E rises; holding E high SHALL yield one enter only.
REQ-015 SETUP + enter -> ARMED, savePW high for that single transition cycle.
REQ-016 ARMED + enter -> CHECK, saveAT high for that single transition cycle.
REQ-017 CHECK SHALL last exactly one cycle, sampling M the cycle after saveAT (datapath register latency 1).
REQ-018 CHECK with M=1 -> OPEN, FAILS cleared to 0.
REQ-019 CHECK with M=0 and FAILS+1 < MAX_FAILS -> ARMED, FAILS incremented.
REQ-020 CHECK with M=0 and FAILS+1 == MAX_FAILS -> LOCKOUT, FAILS set to MAX_FAILS, timer loaded with LOCKOUT_CYCLES-1.
REQ-021 LOCKOUT SHALL decrement the timer each cycle, ignore enter, assert no strobes; at timer 0 -> ARMED, FAILS cleared.
REQ-022 OPEN + enter -> ARMED with savePW high (re-lock with current switch value as new password).
REQ-023 Enter in CHECK SHALL be discarded, not queued.
REQ-024 savePW and saveAT SHALL never be high in the same cycle; at most one strobe per enter.
REQ-025 FAILS SHALL saturate at MAX_FAILS and never wrap.
REQ-026 All outputs SHALL be registered or decoded solely from state registers (no combinational path from E or M).

Reset
REQ-027 reset low SHALL immediately force SETUP, FAILS=0, timer=0, synchronizer flops=0, savePW=0, saveAT=0, LOCKED=0, LOCKOUT=0.
REQ-028 reset asserted mid-LOCKOUT or mid-CHECK SHALL abandon the operation with no strobe emitted afterwards.
REQ-029 After reset release with E already high, no enter SHALL be generated until E falls and rises again.

Structure
REQ-030 safe_pkg SHALL hold the state enum (3-bit) and state encoding constants; PRESENT_STATE uses it.
REQ-031 Synchronizer and edge detect SHALL be sub-module sync_edge (ports CLK50, reset, in, pulse).
REQ-032 Timer width SHALL be $clog2(LOCKOUT_CYCLES)+1 bits, computed locally.

Verification (MAX_FAILS=3, LOCKOUT_CYCLES=8)
REQ-033 Reset, E pulse -> savePW high one cycle 3 cycles after E rise, PRESENT_STATE 0->1, LOCKED=1.
REQ-034 ARMED, E pulse, M=1 -> saveAT one cycle, CHECK one cycle, OPEN, LOCKED=0, FAILS=0.
REQ-035 ARMED, three attempts with M=0 -> FAILS 1,2,3; third CHECK -> LOCKOUT for exactly 8 cycles, then ARMED, FAILS=0.
REQ-036 LOCKOUT, E pulses every 2 cycles -> no savePW/saveAT, exit timing unchanged at 8 cycles.
REQ-037 E held high 20 cycles in ARMED -> exactly one saveAT.
REQ-038 reset pulsed during LOCKOUT cycle 4 -> SETUP immediately, FAILS=0, LOCKOUT=0, no strobes.
